// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bundle
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;
  modport master (output start, a, b, input busy, done, diff, borrow_out, zero);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out, zero);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first unsigned a - b with ripple borrow flip-flop
module serial_subtractor #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  serial_subtractor_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [CW-1:0]    cnt;
  logic             br, d, br_n, accept, last;
  logic [WIDTH-1:0] res;
  assign d      = a_sh[0] ^ b_sh[0] ^ br;
  assign br_n   = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & br) | (b_sh[0] & br);
  assign res    = {d, r_sh[WIDTH-1:1]};
  assign accept = (state == IDLE || state == DONE) && s.start;
  assign last   = state == BUSY && cnt == CW'(WIDTH - 1);
  assign s.busy = state == BUSY;
  assign s.done = state == DONE;
  // launch, shift one bit per BUSY cycle, publish results only on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      a_sh         <= '0;
      b_sh         <= '0;
      r_sh         <= '0;
      cnt          <= '0;
      br           <= 1'b0;
      s.diff       <= '0;
      s.borrow_out <= 1'b0;
      s.zero       <= 1'b0;
    end else begin
      state <= accept ? BUSY : last ? DONE : state == BUSY ? BUSY : IDLE;
      if (accept) begin
        a_sh <= s.a;
        b_sh <= s.b;
        r_sh <= '0;
        br   <= 1'b0;
        cnt  <= '0;
      end else if (state == BUSY) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        r_sh <= res;
        br   <= br_n;
        cnt  <= cnt + 1'b1;
      end
      if (last) begin
        s.diff       <= res;
        s.borrow_out <= br_n;
        s.zero       <= res == '0;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks against an arithmetic model
module tb_serial_subtractor;
  localparam int W = 8;
  logic clk = 0, rst = 1;
  int checks = 0, errors = 0;
  logic [W-1:0] last_diff = '0;
  logic last_br = 0, last_z = 0;
  serial_subtractor_if #(.WIDTH(W)) s ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .s(s));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_done(input bit glitch, output int k);
    k = 0;
    while (!s.done && k < 64) begin
      if (glitch && k == 2) begin
        s.start = 1; s.a = 1; s.b = 2;
      end else if (glitch) s.start = 0;
      @(negedge clk); k++;
      check("overlap", {s.busy, s.done} == 2'b11, 0);
      if (!s.done) check("diff_hold", {s.diff, s.borrow_out, s.zero}, {last_diff, last_br, last_z});
    end
    if (!s.done) check("timeout", 0, 1);
  endtask
  task automatic expect_result(input logic [W-1:0] ta, input logic [W-1:0] tbv, input int k);
    logic [W-1:0] ed;
    ed = ta - tbv;
    check("latency", k, W);
    check("busy_at_done", s.busy, 0);
    check("diff", s.diff, ed);
    check("borrow", s.borrow_out, ta < tbv);
    check("zero", s.zero, ed == 0);
    last_diff = ed; last_br = ta < tbv; last_z = ed == 0;
  endtask
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input bit glitch);
    int k;
    s.start = 1; s.a = ta; s.b = tbv;
    @(negedge clk);
    check("busy_start", {s.busy, s.done}, 2'b10);
    s.start = 0; s.a = W'($urandom); s.b = W'($urandom);
    wait_done(glitch, k);
    expect_result(ta, tbv, k);
    s.start = 0;
    @(negedge clk);
    check("idle_after", {s.busy, s.done}, 2'b00);
    check("diff_idle", s.diff, last_diff);
  endtask
  initial begin
    int k;
    s.start = 0; s.a = 0; s.b = 0;
    repeat (2) @(negedge clk);
    check("rst_out", {s.busy, s.done, s.diff, s.borrow_out, s.zero}, 0);
    rst = 0;
    @(negedge clk);
    check("idle", {s.busy, s.done}, 0);
    op(100, 37, 0);
    op(5, 9, 0);
    op(0, 1, 0);
    op(8'h55, 8'h55, 0);
    op(8'hFF, 0, 0);
    op(200, 50, 1);
    s.start = 1; s.a = 10; s.b = 3;
    @(negedge clk);
    s.a = 3; s.b = 10;
    wait_done(0, k);
    expect_result(10, 3, k);
    @(negedge clk);
    check("b2b_busy", {s.busy, s.done}, 2'b10);
    s.start = 0;
    wait_done(0, k);
    expect_result(3, 10, k);
    @(negedge clk);
    s.start = 1; s.a = 8'h80; s.b = 8'h01;
    @(negedge clk);
    s.start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("rst_mid", {s.busy, s.done, s.diff, s.borrow_out, s.zero}, 0);
    rst = 0;
    last_diff = 0; last_br = 0; last_z = 0;
    k = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      k += s.done;
    end
    check("no_done_after_rst", k, 0);
    op(8'h80, 8'h01, 0);
    for (int i = 0; i < 40; i++) op(W'($urandom), W'($urandom), $urandom_range(0, 1) == 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
